// File: rtl/multi_channel_timer_if.sv
// Bus bundle for multi_channel_timer: configuration, per-channel control
// strobes, the readback port and the status outputs.
// Optional feature macro: TIMER_IRQ_EN adds irq (timer -> system) and
// irq_clr (system -> timer).
interface multi_channel_timer_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
);
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [WIDTH-1:0]    cfg_limit;
    logic                cfg_mode;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic                tick_en;
    logic [CH_W-1:0]     rd_ch;
    logic [WIDTH-1:0]    rd_count;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] counter_done;
`ifdef TIMER_IRQ_EN
    logic                irq;
    logic                irq_clr;

    modport master (
        output cfg_we, cfg_ch, cfg_limit, cfg_mode, start, stop, tick_en, rd_ch, irq_clr,
        input  rd_count, busy, counter_done, irq
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_limit, cfg_mode, start, stop, tick_en, rd_ch, irq_clr,
        output rd_count, busy, counter_done, irq
    );
`else
    modport master (
        output cfg_we, cfg_ch, cfg_limit, cfg_mode, start, stop, tick_en, rd_ch,
        input  rd_count, busy, counter_done
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_limit, cfg_mode, start, stop, tick_en, rd_ch,
        output rd_count, busy, counter_done
    );
`endif
endinterface

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: CHANNELS independent WIDTH-bit up-counters sharing a
// count strobe. Each channel has shadow limit/mode registers that are copied
// into the active set on start, a one-shot or auto-reload mode, and a
// registered one-cycle counter_done pulse at the terminal count.
// Optional feature macro: TIMER_IRQ_EN adds a sticky interrupt (irq) that
// collects all done pulses and is cleared by irq_clr.
module multi_channel_timer #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    multi_channel_timer_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Per-channel state (registers) and their next values.
    state_e              state_r     [CHANNELS];
    state_e              state_s     [CHANNELS];
    logic [WIDTH-1:0]    count_r     [CHANNELS];
    logic [WIDTH-1:0]    count_s     [CHANNELS];
    logic [WIDTH-1:0]    act_limit_r [CHANNELS];
    logic [WIDTH-1:0]    act_limit_s [CHANNELS];
    logic                act_mode_r  [CHANNELS];
    logic                act_mode_s  [CHANNELS];
    logic [WIDTH-1:0]    shd_limit_r [CHANNELS];
    logic [WIDTH-1:0]    shd_limit_s [CHANNELS];
    logic                shd_mode_r  [CHANNELS];
    logic                shd_mode_s  [CHANNELS];

    // Config source for a (re)start: the incoming write when it targets this
    // channel in the same cycle, otherwise the stored shadow.
    logic                cfg_hit_s   [CHANNELS];
    logic [WIDTH-1:0]    src_limit_s [CHANNELS];
    logic                src_mode_s  [CHANNELS];

    logic [CHANNELS-1:0] done_s;
    logic [CHANNELS-1:0] done_r;
    logic [CHANNELS-1:0] busy_s;
    logic [WIDTH-1:0]    rd_sel_s;
    logic [WIDTH-1:0]    rd_count_r;

`ifdef TIMER_IRQ_EN
    logic                irq_s;
    logic                irq_r;
`endif

    // State register: all per-channel registers plus the registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i]     <= ST_IDLE;
                count_r[i]     <= {WIDTH{1'b0}};
                act_limit_r[i] <= {WIDTH{1'b0}};
                act_mode_r[i]  <= 1'b0;
                shd_limit_r[i] <= {WIDTH{1'b0}};
                shd_mode_r[i]  <= 1'b0;
            end
            done_r     <= {CHANNELS{1'b0}};
            rd_count_r <= {WIDTH{1'b0}};
`ifdef TIMER_IRQ_EN
            irq_r      <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i]     <= state_s[i];
                count_r[i]     <= count_s[i];
                act_limit_r[i] <= act_limit_s[i];
                act_mode_r[i]  <= act_mode_s[i];
                shd_limit_r[i] <= shd_limit_s[i];
                shd_mode_r[i]  <= shd_mode_s[i];
            end
            done_r     <= done_s;
            rd_count_r <= rd_sel_s;
`ifdef TIMER_IRQ_EN
            irq_r      <= irq_s;
`endif
        end
    end

    // Next-state logic: per-channel FSM, counting, shadow/active config.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_s[i]     = state_r[i];
            count_s[i]     = count_r[i];
            act_limit_s[i] = act_limit_r[i];
            act_mode_s[i]  = act_mode_r[i];
            done_s[i]      = 1'b0;

            // An out-of-range cfg_ch matches no channel, so the write is dropped.
            cfg_hit_s[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
            if (cfg_hit_s[i]) begin
                src_limit_s[i] = bus.cfg_limit;
                src_mode_s[i]  = bus.cfg_mode;
            end else begin
                src_limit_s[i] = shd_limit_r[i];
                src_mode_s[i]  = shd_mode_r[i];
            end
            shd_limit_s[i] = src_limit_s[i];
            shd_mode_s[i]  = src_mode_s[i];

            case (state_r[i])
                ST_IDLE: begin
                    // stop beats start; tick_en is irrelevant while idle.
                    if (bus.stop[i]) begin
                        state_s[i] = ST_IDLE;
                    end else if (bus.start[i]) begin
                        state_s[i]     = ST_RUN;
                        count_s[i]     = {WIDTH{1'b0}};
                        act_limit_s[i] = src_limit_s[i];
                        act_mode_s[i]  = src_mode_s[i];
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.stop[i]) begin
                        // Count is frozen so it can still be read back.
                        state_s[i] = ST_IDLE;
                    end else if (bus.start[i]) begin
                        // Restart: the tick in this cycle is ignored.
                        state_s[i]     = ST_RUN;
                        count_s[i]     = {WIDTH{1'b0}};
                        act_limit_s[i] = src_limit_s[i];
                        act_mode_s[i]  = src_mode_s[i];
                    end else if (bus.tick_en) begin
                        if (count_r[i] == act_limit_r[i]) begin
                            done_s[i]  = 1'b1;
                            count_s[i] = {WIDTH{1'b0}};
                            state_s[i] = act_mode_r[i] ? ST_RUN : ST_IDLE;
                        end else begin
                            count_s[i] = count_r[i] + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_s[i] = ST_RUN;
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                    count_s[i] = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Output logic: busy flags and the readback mux feeding rd_count_r.
    always_comb begin
        busy_s   = {CHANNELS{1'b0}};
        rd_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            busy_s[i] = (state_r[i] == ST_RUN);
            // Out-of-range rd_ch matches nothing and reads as zero.
            rd_sel_s  = (bus.rd_ch == CH_W'(i)) ? count_r[i] : rd_sel_s;
        end
    end

`ifdef TIMER_IRQ_EN
    // Sticky interrupt: any done pulse sets it and takes priority over a clear.
    always_comb begin
        if (|done_r) begin
            irq_s = 1'b1;
        end else if (bus.irq_clr) begin
            irq_s = 1'b0;
        end else begin
            irq_s = irq_r;
        end
    end

    assign bus.irq = irq_r;
`endif

    assign bus.busy         = busy_s;
    assign bus.counter_done = done_r;
    assign bus.rd_count     = rd_count_r;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer. Stimulus pushes expected
// output values tagged with the clock edge after which they must hold; a
// monitor on the falling edge pops and compares every entry due.
module tb_multi_channel_timer;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    localparam int K_DONE = 0;
    localparam int K_BUSY = 1;
    localparam int K_RD   = 2;
    localparam int K_IRQ  = 3;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    exp_t sb[$];

    multi_channel_timer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) bus ();

    multi_channel_timer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_DONE:  return "counter_done";
            K_BUSY:  return "busy";
            K_RD:    return "rd_count";
            K_IRQ:   return "irq";
            default: return "unknown";
        endcase
    endfunction

    function automatic int actual(int k);
        case (k)
            K_DONE:  return int'(bus.counter_done);
            K_BUSY:  return int'(bus.busy);
            K_RD:    return int'(bus.rd_count);
`ifdef TIMER_IRQ_EN
            K_IRQ:   return int'(bus.irq);
`endif
            default: return -1;
        endcase
    endfunction

    function automatic void push(int at, int kind, int val);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endfunction

    function automatic void push_done(int a, int b, int val);
        for (int e = a; e <= b; e++) push(e, K_DONE, val);
    endfunction

    // Monitor: compare every scoreboard entry due after the latest edge.
    always @(negedge sys_clk) begin
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc == cyc) begin
                total = total + 1;
                if (actual(sb[j].kind) != sb[j].val) begin
                    bad = bad + 1;
                    $display("FAIL %s at edge %0d: got %0d expected %0d",
                             kname(sb[j].kind), cyc, actual(sb[j].kind), sb[j].val);
                end
                sb.delete(j);
            end else if (sb[j].cyc < cyc) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL %s stale entry for edge %0d (now %0d)", kname(sb[j].kind), sb[j].cyc, cyc);
                sb.delete(j);
            end
        end
    end

    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_to(int e);
        while (cyc < e) cycle();
    endtask

    task automatic cfg(int ch, int lim, int mode);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_limit = WIDTH'(lim);
        bus.cfg_mode  = mode[0];
        cycle();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_limit = '0;
        bus.cfg_mode  = 1'b0;
        bus.start     = '0;
        bus.stop      = '0;
        bus.tick_en   = 1'b0;
        bus.rd_ch     = '0;
`ifdef TIMER_IRQ_EN
        bus.irq_clr   = 1'b0;
`endif
    endtask

    task automatic random_inputs();
        bus.cfg_we    = 1'($urandom);
        bus.cfg_ch    = CH_W'($urandom);
        bus.cfg_limit = WIDTH'($urandom);
        bus.cfg_mode  = 1'($urandom);
        bus.start     = CHANNELS'($urandom);
        bus.stop      = CHANNELS'($urandom);
        bus.tick_en   = 1'($urandom);
        bus.rd_ch     = CH_W'($urandom);
`ifdef TIMER_IRQ_EN
        bus.irq_clr   = 1'($urandom);
`endif
    endtask

    initial begin
        int s;
        int s2;
        int s3;
        int t;
        int v;
        bit tk;

        // Reset for two cycles with random inputs.
        rst = 1'b1;
        random_inputs();
        for (int e = 1; e <= 2; e++) begin
            push(e, K_BUSY, 0);
            push(e, K_DONE, 0);
            push(e, K_RD, 0);
`ifdef TIMER_IRQ_EN
            push(e, K_IRQ, 0);
`endif
        end
        cycle();
        random_inputs();
        cycle();
        rst = 1'b0;
        clear_inputs();

        // One-shot ch0, limit 3.
        cfg(0, 3, 0);
        s = cyc + 1;
        bus.start   = 4'b0001;
        bus.tick_en = 1'b1;
        push(s, K_BUSY, 1);
        push_done(s, s + 3, 0);
        push(s + 4, K_DONE, 1);
        push(s + 4, K_BUSY, 0);
        push(s + 5, K_DONE, 0);
        push(s + 2, K_RD, 1);
        push(s + 4, K_RD, 3);
        push(s + 5, K_RD, 0);
        push(s + 6, K_RD, 0);
        cycle();
        bus.start = '0;
        run_to(s + 6);
        bus.tick_en = 1'b0;

        // Auto-reload ch1 (L=2) and ch2 (L=0) in parallel.
        cfg(1, 2, 1);
        cfg(2, 0, 1);
        s = cyc + 1;
        bus.start   = 4'b0110;
        bus.tick_en = 1'b1;
        push(s, K_BUSY, 6);
        push(s + 15, K_BUSY, 6);
        push(s + 20, K_BUSY, 6);
        push(s + 27, K_BUSY, 6);
        for (int e = s; e <= s + 15; e++) begin
            v = 0;
            if (e > s) v = v | 4;
            if (e > s && ((e - s) % 3) == 0) v = v | 2;
            push(e, K_DONE, v);
        end
        cycle();
        bus.start = '0;
        run_to(s + 15);
        // tick_en toggled: only odd offsets from s tick; ch1 period becomes 6.
        for (int c = s + 15; c <= s + 26; c++) begin
            tk = (((c + 1 - s) % 2) == 1);
            bus.tick_en = tk;
            v = 0;
            if (tk) v = v | 4;
            if (c + 1 == s + 21 || c + 1 == s + 27) v = v | 2;
            push(c + 1, K_DONE, v);
            cycle();
        end
        bus.tick_en = 1'b0;
        bus.stop    = 4'b0110;
        push(s + 28, K_DONE, 0);
        push(s + 28, K_BUSY, 0);
        cycle();
        bus.stop = '0;

        // Stop at count 2: busy drops, count held and readable.
        bus.tick_en = 1'b1;
        bus.rd_ch   = 2'd0;
        s = cyc + 1;
        bus.start = 4'b0001;
        push(s, K_BUSY, 1);
        push_done(s, s + 6, 0);
        push(s + 3, K_BUSY, 0);
        push(s + 4, K_RD, 2);
        push(s + 6, K_RD, 2);
        cycle();
        bus.start = '0;
        run_to(s + 2);
        bus.stop = 4'b0001;
        cycle();
        bus.stop = '0;
        run_to(s + 6);

        // start and stop together in IDLE: stays idle, count untouched.
        t = cyc + 1;
        bus.start = 4'b0001;
        bus.stop  = 4'b0001;
        push(t, K_BUSY, 0);
        push(t, K_DONE, 0);
        push(t + 1, K_DONE, 0);
        push(t + 1, K_RD, 2);
        push(t + 2, K_RD, 2);
        cycle();
        bus.start = '0;
        bus.stop  = '0;
        run_to(t + 2);

        // Restart at count 2: count returns to 0 with no done pulse.
        s = cyc + 1;
        bus.start = 4'b0001;
        push(s, K_BUSY, 1);
        push_done(s, s + 6, 0);
        push(s + 3, K_BUSY, 1);
        push(s + 3, K_RD, 2);
        push(s + 4, K_RD, 0);
        push(s + 7, K_DONE, 1);
        push(s + 7, K_BUSY, 0);
        push(s + 8, K_DONE, 0);
        cycle();
        bus.start = '0;
        run_to(s + 2);
        bus.start = 4'b0001;
        cycle();
        bus.start = '0;
        run_to(s + 8);

        // Shadow config: a write during a run does not alter that run.
        cfg(0, 5, 0);
        s = cyc + 1;
        bus.start = 4'b0001;
        push(s, K_BUSY, 1);
        push_done(s, s + 5, 0);
        push(s + 6, K_DONE, 1);
        push(s + 6, K_BUSY, 0);
        push(s + 7, K_DONE, 0);
        cycle();
        bus.start = '0;
        cfg(0, 1, 0);
        run_to(s + 7);

        // Next start uses the new limit 1.
        s2 = cyc + 1;
        bus.start = 4'b0001;
        push(s2, K_BUSY, 1);
        push(s2 + 1, K_BUSY, 1);
        push_done(s2, s2 + 1, 0);
        push(s2 + 2, K_DONE, 1);
        push(s2 + 2, K_BUSY, 0);
        push(s2 + 3, K_DONE, 0);
        cycle();
        bus.start = '0;
        run_to(s2 + 3);

        // Config write and start together: limit 2 is bypassed into the run.
        s3 = cyc + 1;
        bus.start     = 4'b0001;
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_limit = 8'd2;
        bus.cfg_mode  = 1'b0;
        push(s3, K_BUSY, 1);
        push_done(s3, s3 + 2, 0);
        push(s3 + 3, K_DONE, 1);
        push(s3 + 3, K_BUSY, 0);
        push(s3 + 4, K_DONE, 0);
        cycle();
        bus.start  = '0;
        bus.cfg_we = 1'b0;
        run_to(s3 + 4);

        // Reset in the middle of a run with every channel busy.
        cfg(0, 100, 0);
        cfg(1, 100, 1);
        cfg(2, 100, 0);
        cfg(3, 100, 1);
        bus.rd_ch = 2'd3;
        s = cyc + 1;
        bus.start = 4'b1111;
        push(s, K_BUSY, 15);
        push(s + 5, K_BUSY, 15);
        push(s + 5, K_RD, 4);
        push_done(s, s + 9, 0);
        push(s + 6, K_BUSY, 0);
        push(s + 9, K_BUSY, 0);
        push(s + 6, K_RD, 0);
        push(s + 7, K_RD, 0);
`ifdef TIMER_IRQ_EN
        push(s + 6, K_IRQ, 0);
`endif
        cycle();
        bus.start = '0;
        run_to(s + 5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run_to(s + 9);

`ifdef TIMER_IRQ_EN
        // Sticky irq: set after a done pulse; a concurrent clear loses.
        cfg(0, 1, 0);
        bus.rd_ch   = 2'd0;
        bus.tick_en = 1'b1;
        s = cyc + 1;
        bus.start = 4'b0001;
        push(s, K_IRQ, 0);
        push(s + 2, K_IRQ, 0);
        push(s + 2, K_DONE, 1);
        push(s + 3, K_IRQ, 1);
        push(s + 4, K_IRQ, 0);
        push(s + 5, K_IRQ, 0);
        push(s + 6, K_IRQ, 0);
        push(s + 6, K_DONE, 1);
        push(s + 7, K_IRQ, 1);
        push(s + 8, K_IRQ, 0);
        cycle();
        bus.start = '0;
        run_to(s + 3);
        bus.irq_clr = 1'b1;
        bus.start   = 4'b0001;
        cycle();
        bus.irq_clr = 1'b0;
        bus.start   = '0;
        run_to(s + 6);
        bus.irq_clr = 1'b1;
        cycle();
        cycle();
        bus.irq_clr = 1'b0;
        run_to(s + 9);
`endif

        clear_inputs();
        run_to(cyc + 3);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
            total = total + 1;
            bad   = bad + 1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
